mult_rr_sched: RTL and testbench
================================

# mult_rr_sched

Round-robin scheduler that shares one iterative shift-add multiplier (`itmult`) between two requesters. It latches the winning requester's operands and drives the multiplier's `start` through a load cycle and SIZE compute cycles. It captures the product when `fin` is seen and returns it with a one-cycle `done` pulse. It sits between the two client blocks and a single `itmult #(SIZE)` instance, and checks that `fin` arrives in the expected cycle.

## Interface
- SIZE, default 6: operand width; must equal the attached `itmult` SIZE (≥2).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; also wired to the `itmult` reset (this block does not generate it).
- req  in  2  request level per requester (bit 0 = requester 0).
- a0, b0  in  SIZE each  operands of requester 0.
- a1, b1  in  SIZE each  operands of requester 1.
- gnt  out  2  one-hot grant; high from LOAD through DONE.
- done  out  2  one-hot completion pulse, high for exactly the DONE cycle.
- P  out  2*SIZE  product of the last completed job; held until the next capture.
- err  out  1  sequencing-fault flag for the last job; held and updated together with P.
- busy  out  1  high whenever state ≠ IDLE.
- mA, mB  out  SIZE each  operands to the multiplier, driven from internal operand registers.
- mstart  out  1  `start` to the multiplier (0 = load, 1 = shift-add).
- mHM, mLM  in  SIZE each  multiplier product halves.
- mfin  in  1  multiplier `fin`.

## Operation
- **States:** IDLE, LOAD, RUN, DONE. Encoding is free.
- **IDLE:**
  - mstart=0.
  - If req≠0, pick a winner, capture its a/b into the operand registers, set gnt and go to LOAD. Otherwise stay.
- **Arbitration:**
  - A single request is always granted.
  - When both bits are set, grant the requester named by the priority pointer `ptr`.
  - `ptr` resets to 0. On leaving DONE it is set to the requester not just served.
- **LOAD:** one cycle, mstart=0. The multiplier loads mB and its counter loads 1. Go to RUN and clear the RUN cycle counter `k`.
- **RUN:**
  - mstart=1. `k` counts RUN cycles 1..SIZE+1.
  - Expected behaviour: mfin=0 in cycles 1..SIZE and mfin=1 in cycle SIZE+1.
  - RUN always ends at the end of cycle SIZE+1. At that edge, P←{mHM,mLM}, err←(mfin low in cycle SIZE+1) OR (mfin seen high in any cycle 1..SIZE), then go to DONE.
  - A sticky internal flag records any early mfin.
- **DONE:**
  - mstart=0, done[granted]=1, gnt still asserted.
  - Update `ptr`, clear gnt at the exit edge and go to IDLE.
- **Handshake:**
  - The requester holds req until it samples done high, then drops req at that same edge.
  - Operands need only be valid in the IDLE cycle where the grant is made; the block keeps its own copies.
  - req high in IDLE is always treated as a new request.
- **Arithmetic:** unsigned SIZE×SIZE → 2*SIZE with no truncation. err does not alter P; P always reflects the sampled multiplier output.

## Timing
- **Reset values:** state=IDLE, gnt=0, done=0, P=0, err=0, busy=0, mstart=0, mA=mB=0, ptr=0, k=0.
- **Reset mid-operation:** the job is aborted immediately, no done is issued, and P/err are cleared.
- **Cycle numbering** from the IDLE cycle where req is sampled (cycle 0):
  - LOAD is cycle 1.
  - RUN is cycles 2..SIZE+2.
  - DONE is cycle SIZE+3.
- **Latency:** req to done is SIZE+3 cycles. P and err are valid from the DONE cycle.
- **Throughput:** back-to-back jobs take SIZE+4 cycles each, because one IDLE cycle always separates jobs. There is no IDLE bypass.
- **Simultaneous events:**
  - req changing during LOAD, RUN or DONE is ignored.
  - The other requester waits; its req stays high until it is granted.
  - A request arriving in the DONE cycle is arbitrated in the following IDLE cycle with the updated `ptr`.
- mstart depends only on the registered state (no combinational path from req or mfin).

## Test plan
- **Single job:** SIZE=4, req=01 with a0=5, b0=3.
  - gnt=01 in cycles 1..7, done=01 in cycle 7.
  - P=15, err=0, busy low again in cycle 8.
- **Maximum operands:** SIZE=4, a1=15, b1=15, req=10. P=225, err=0 and done=10 in cycle 7.
- **Contention after reset:** req=11 with (a0,b0)=(6,7) and (a1,b1)=(9,4).
  - Requester 0 is served first with P=42.
  - Requester 1 is granted in the following IDLE cycle and gets P=36.
  - Both stay held high until their own done.
- **Fairness:** req held at 11 for 4 jobs. Grants alternate 0,1,0,1 and each done is spaced SIZE+4=8 cycles apart.
- **Fault injection:** mfin forced to 0. The job still completes in cycle 7 with err=1. With mfin forced to 1, err=1 as well.
- **Reset mid-RUN:** assert reset in cycle 4 of a job. All outputs go to 0 immediately, no done pulse appears, and a subsequent req=01 job with 2×3 completes normally with P=6.

Source files
------------

// File: rtl/mult_rr_sched.sv
// Round-robin front end that shares one iterative itmult between
// two requesters, returning each product with a one-cycle done pulse.
module mult_rr_sched #(
  parameter int SIZE = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [SIZE-1:0]   a0,
  input  logic [SIZE-1:0]   b0,
  input  logic [SIZE-1:0]   a1,
  input  logic [SIZE-1:0]   b1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [2*SIZE-1:0] P,
  output logic              err,
  output logic              busy,
  output logic [SIZE-1:0]   mA,
  output logic [SIZE-1:0]   mB,
  output logic              mstart,
  input  logic [SIZE-1:0]   mHM,
  input  logic [SIZE-1:0]   mLM,
  input  logic              mfin
);

  localparam int KW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic [2*SIZE-1:0] r_P;
  logic              r_err;
  logic              r_busy;
  logic              r_mstart;
  logic [SIZE-1:0]   r_mA;
  logic [SIZE-1:0]   r_mB;
  logic              r_ptr;
  logic              r_early;
  logic [KW-1:0]     r_k;

  logic w_pick1;
  logic w_last;

  // requester 1 wins when alone, or when both ask and ptr names it
  assign w_pick1 = req[1] & (~req[0] | r_ptr);
  // r_k holds completed RUN cycles, so SIZE means the final cycle
  assign w_last  = (r_k == KW'(SIZE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_P      <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_mstart <= 1'b0;
      r_mA     <= '0;
      r_mB     <= '0;
      r_ptr    <= 1'b0;
      r_early  <= 1'b0;
      r_k      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
            r_mA    <= w_pick1 ? a1 : a0;
            r_mB    <= w_pick1 ? b1 : b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_k      <= '0;
          r_early  <= 1'b0;
          r_mstart <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          if (w_last) begin
            r_P      <= {mHM, mLM};
            r_err    <= r_early | ~mfin;
            r_mstart <= 1'b0;
            r_done   <= r_gnt;
            r_state  <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
            if (mfin) r_early <= 1'b1;
          end
        end
        S_DONE: begin
          r_ptr   <= r_gnt[0];
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign P      = r_P;
  assign err    = r_err;
  assign busy   = r_busy;
  assign mstart = r_mstart;
  assign mA     = r_mA;
  assign mB     = r_mB;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched with a shift-add itmult stand-in and a
// job-level reference model for grants, timing and products.
module tb_mult_rr_sched;

  localparam int SIZE = 4;
  localparam int PW   = 2 * SIZE;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req;
  logic [SIZE-1:0] a0, b0, a1, b1;
  logic [1:0]      gnt, done;
  logic [PW-1:0]   P;
  logic            err, busy, mstart, mfin;
  logic [SIZE-1:0] mA, mB, mHM, mLM;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_done = -1;
  bit         m_ptr = 1'b0;
  logic [1:0] fmode = 2'd0;

  always #5 clk = ~clk;

  mult_rr_sched #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .P(P), .err(err),
    .busy(busy), .mA(mA), .mB(mB),
    .mstart(mstart), .mHM(mHM), .mLM(mLM),
    .mfin(mfin)
  );

  // itmult stand-in: load on start=0, one shift-add step per cycle
  logic [SIZE-1:0] t_HM, t_LM;
  logic [SIZE:0]   t_s;
  int              t_cnt;

  assign t_s = {1'b0, t_HM} + (t_LM[0] ? {1'b0, mA} : '0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_HM <= '0; t_LM <= '0; t_cnt <= 0;
    end else if (!mstart) begin
      t_HM <= '0; t_LM <= mB; t_cnt <= 1;
    end else if (t_cnt <= SIZE) begin
      t_HM  <= t_s[SIZE:1];
      t_LM  <= {t_s[0], t_LM[SIZE-1:1]};
      t_cnt <= t_cnt + 1;
    end
  end

  assign mHM  = t_HM;
  assign mLM  = t_LM;
  assign mfin = (fmode == 2'd0) ? (t_cnt == SIZE + 1)
              : (fmode == 2'd2);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input int r);
    if (r == 0) begin
      a0 = SIZE'($urandom); b0 = SIZE'($urandom);
    end else begin
      a1 = SIZE'($urandom); b1 = SIZE'($urandom);
    end
  endtask

  // Called in an IDLE cycle with req != 0; ends in the next IDLE cycle
  task automatic run_job(input string tag, input logic [1:0] fm,
                         input bit spacing, input bit late,
                         output int w_o);
    int         w;
    logic [1:0] oh;
    int         ea, eb;
    logic [PW-1:0] exp_p;
    w  = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : int'(m_ptr);
    oh = (w == 1) ? 2'b10 : 2'b01;
    ea = (w == 1) ? int'(a1) : int'(a0);
    eb = (w == 1) ? int'(b1) : int'(b0);
    exp_p = PW'(ea * eb);
    fmode = fm;
    for (int c = 1; c <= SIZE + 3; c++) begin
      tick();
      if (c == 2) set_ops(w);
      if (c == 3 && late && !req[1-w] && $urandom_range(0, 1) == 1) begin
        set_ops(1 - w);
        req[1-w] = 1'b1;
      end
      chk($sformatf("%s c%0d gnt/done/busy/mstart", tag, c),
          {gnt, done, busy, mstart},
          {oh, (c == SIZE + 3) ? oh : 2'b00, 1'b1,
           (c >= 2 && c <= SIZE + 2)});
      if (c == SIZE + 2)
        chk({tag, " operands"}, {mA, mB}, {SIZE'(ea), SIZE'(eb)});
    end
    chk({tag, " P"}, P, exp_p);
    chk({tag, " err"}, err, fm != 2'd0);
    if (spacing && last_done >= 0)
      chk({tag, " done spacing"}, cyc - last_done, SIZE + 4);
    last_done = cyc;
    req[w] = 1'b0;
    m_ptr  = (w == 0);
    fmode  = 2'd0;
    tick();
    chk({tag, " idle ctl"}, {gnt, done, busy, mstart}, 6'd0);
    chk({tag, " P held"}, P, exp_p);
    w_o = w;
  endtask

  initial begin
    int w;
    logic [1:0] fm;
    reset = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset ctl", {gnt, done, busy, mstart, err}, 7'd0);
    chk("reset P", P, 0);
    chk("reset mA/mB", {mA, mB}, 0);
    tick();

    // contention right after reset: requester 0 first
    a0 = 4'd6; b0 = 4'd7; a1 = 4'd9; b1 = 4'd4;
    req = 2'b11;
    run_job("contend0", 2'd0, 0, 0, w);
    chk("contend req1 held", req, 2'b10);
    run_job("contend1", 2'd0, 0, 0, w);

    a0 = 4'd5; b0 = 4'd3; req = 2'b01;
    run_job("single", 2'd0, 0, 0, w);

    a1 = 4'd15; b1 = 4'd15; req = 2'b10;
    run_job("maxops", 2'd0, 0, 0, w);

    // fairness: both requesters re-raise immediately after their done
    last_done = -1;
    for (int j = 0; j < 4; j++) begin
      if (!req[0]) set_ops(0);
      if (!req[1]) set_ops(1);
      req = 2'b11;
      run_job($sformatf("fair%0d", j), 2'd0, 1, 0, w);
    end
    for (int d = 0; d < 2 && req != 2'b00; d++)
      run_job("drain", 2'd0, 0, 0, w);

    a0 = 4'd5; b0 = 4'd3; req = 2'b01;
    run_job("fin_stuck0", 2'd1, 0, 0, w);
    a0 = 4'd5; b0 = 4'd3; req = 2'b01;
    run_job("fin_stuck1", 2'd2, 0, 0, w);

    for (int j = 0; j < 30; j++) begin
      for (int r = 0; r < 2; r++)
        if (!req[r] && $urandom_range(0, 1) == 1) begin
          set_ops(r);
          req[r] = 1'b1;
        end
      if (req == 2'b00) begin
        set_ops(0);
        req[0] = 1'b1;
      end
      fm = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 2))
                                      : 2'd0;
      run_job($sformatf("rnd%0d", j), fm, 0, 1, w);
    end
    for (int d = 0; d < 2 && req != 2'b00; d++)
      run_job("drain", 2'd0, 0, 0, w);

    // reset in cycle 4 of a job aborts it
    a0 = 4'd7; b0 = 4'd5; req = 2'b01;
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b1;
    #1;
    chk("midrst ctl", {gnt, done, busy, mstart, err}, 7'd0);
    chk("midrst P", P, 0);
    chk("midrst mA/mB", {mA, mB}, 0);
    req = 2'b00;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("midrst no done", {done, busy}, 3'd0);
    end
    reset = 1'b0;
    m_ptr = 1'b0;
    tick();
    a0 = 4'd2; b0 = 4'd3; req = 2'b01;
    run_job("post_reset", 2'd0, 0, 0, w);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
